mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the ARM core's data port (LDR/STR/LDRB/STRB) and a word-wide synchronous SRAM with 1-cycle read latency and no byte enables.
- Implements STRB as read-modify-write.
- For LDRB, selects the byte lane from addr[1:0] and zero-extends it.
- The core holds its request until a one-cycle ready pulse.

Parameters:
- ADDR_W, 6, word-address width of the SRAM (64 words).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  core access request; held stable until ready
- we  in  1  1 = store, 0 = load
- byte_en  in  1  1 = byte access (LDRB/STRB), 0 = word access
- addr  in  32  byte address
- wdata  in  32  store data; STRB uses wdata[7:0]
- ready  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while ready=1
- err  out  1  misaligned word access; valid with ready
- busy  out  1  high in every state except IDLE
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write strobe (qualified by mem_en)
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data; valid the cycle after a read strobe

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; latched request registers cleared.
  - ready=0, err=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Asserting reset mid-operation aborts the operation; no SRAM strobe after reset asserts.
  - A STRB aborted before MERGE leaves memory unmodified.
- Word address is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- States: IDLE, RDATA, MERGE, DONE.
- IDLE:
  - When req=1, the request is accepted and we, byte_en, addr[1:0], word address and wdata are latched.
  - SRAM outputs are driven combinationally from the inputs in the same cycle.
  - Misaligned word access (byte_en=0, addr[1:0]!=0): mem_en=0, err flag latched, go to DONE.
  - STR: mem_en=1, mem_we=1, mem_wdata=wdata, go to DONE.
  - LDR/LDRB: mem_en=1, mem_we=0, go to RDATA.
  - STRB: mem_en=1, mem_we=0, go to MERGE.
- RDATA:
  - LDR: rdata register <= mem_rdata.
  - LDRB: rdata register <= {24'b0, mem_rdata[8*addr[1:0]+7 -: 8]}.
  - Go to DONE. mem_en=0.
- MERGE:
  - mem_en=1, mem_we=1, latched word address.
  - mem_wdata = mem_rdata with lane addr[1:0] replaced by wdata[7:0]; other lanes unchanged.
  - Go to DONE.
- DONE:
  - ready=1 for exactly one cycle; err=1 if the latched error flag is set.
  - rdata holds the load result; it is 0 for stores and errors.
  - Go to IDLE. req is ignored in DONE; a back-to-back request is accepted in the following IDLE cycle.
- Latency from the accept cycle (cycle 0) to ready:
  - STR: cycle 1
  - misaligned access: cycle 1
  - LDR/LDRB: cycle 2
  - STRB: cycle 2
- Inputs changing after accept are ignored until the next IDLE.
- busy is registered state decode (state != IDLE), so it lags accept by one cycle.
- A req dropped mid-operation does not cancel it; ready still pulses.

Decomposition:
- Package arm_mem_pkg:
  - typedef enum logic [1:0] mem_state_t {IDLE, RDATA, MERGE, DONE}
  - localparam BYTE_W = 8
  - function lane_shift(addr[1:0]) returning the bit offset
- Sub-module byte_lane (combinational), used by RDATA and MERGE:
  - extract: byte select and zero-extend
  - merge: byte insert
- Top level holds the FSM, request latches and rdata register.

Test Plan:
- Reset: reset_n=0 for 2 cycles mid-STRB (in MERGE-pending cycle 0) -> all outputs 0, state IDLE, no mem_we pulse, memory word unchanged.
- Word store then load: STR addr=0x64 wdata=0x00000007 -> ready at cycle 1, SRAM word 25 = 0x00000007. Then LDR addr=0x64 -> ready at cycle 2, rdata=0x00000007, err=0.
- Byte load: preload word 24 = 0xAABBCCDD. LDRB addr=0x61 -> rdata=0x000000CC. LDRB addr=0x63 -> rdata=0x000000AA.
- Byte store: word 24 = 0xAABBCCDD, STRB addr=0x62 wdata=0x12345611 -> read strobe then write strobe, word 24 = 0xAA11CCDD, ready at cycle 2.
- Misaligned access: LDR addr=0x66 -> no mem_en, ready+err at cycle 1, rdata=0. Next aligned request is accepted normally.
- Wrap and back-to-back: STR addr=0x100 (ADDR_W=6) -> word 0 written. Immediately re-asserting req in DONE is accepted on the next cycle, and busy tracks each operation.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the ARM data-port load/store unit.
// Lanes are little-endian: byte lane N occupies bits [8N+7:8N] of the word.
package arm_mem_pkg;

   typedef enum logic [1:0] {IDLE, RDATA, MERGE, DONE} mem_state_t;

   localparam int BYTE_W = 8;

   function automatic logic [4:0] lane_shift(input logic [1:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational byte-lane helper: zero-extended byte extract for LDRB and
// single-lane insert for the STRB read-modify-write.
module byte_lane
   import arm_mem_pkg::*;
(
   input  logic [31:0]       word,
   input  logic [1:0]        lane,
   input  logic [BYTE_W-1:0] wbyte,
   output logic [31:0]       extract,
   output logic [31:0]       merged
);

   always_comb begin
      extract                           = '0;
      extract[BYTE_W-1:0]               = word[lane_shift(lane) +: BYTE_W];
      merged                            = word;
      merged[lane_shift(lane) +: BYTE_W] = wbyte;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the core data port and a word-wide,
// 1-cycle-latency SRAM without byte enables (STRB done as read-modify-write).
module mem_access_unit
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              we,
   input  logic              byte_en,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              err,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   mem_state_t        state_q, state_d;
   logic              byte_q, byte_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [BYTE_W-1:0] wbyte_q, wbyte_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       lane_ext, lane_merged;
   logic              misaligned;

   // Address bits above the SRAM word range are intentionally dropped (wrap).
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   byte_lane u_byte_lane (
      .word    (mem_rdata),
      .lane    (lane_q),
      .wbyte   (wbyte_q),
      .extract (lane_ext),
      .merged  (lane_merged)
   );

   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      lane_d     = lane_q;
      waddr_d    = waddr_q;
      wbyte_d    = wbyte_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = waddr_q;
      mem_wdata  = '0;
      misaligned = !byte_en && (addr[1:0] != 2'b00);
      case (state_q)
         IDLE: begin
            // reset_n gates the same-cycle strobes so an asserted reset never reaches the SRAM.
            if (req && reset_n) begin
               byte_d   = byte_en;
               lane_d   = addr[1:0];
               waddr_d  = addr[ADDR_W+1:2];
               wbyte_d  = wdata[BYTE_W-1:0];
               err_d    = misaligned;
               rdata_d  = '0;
               mem_addr = addr[ADDR_W+1:2];
               if (misaligned) begin
                  state_d = DONE;
               end else begin
                  mem_en = 1'b1;
                  if (we && !byte_en) begin
                     mem_we    = 1'b1;
                     mem_wdata = wdata;
                     state_d   = DONE;
                  end else if (we) begin
                     state_d = MERGE;
                  end else begin
                     state_d = RDATA;
                  end
               end
            end
         end
         RDATA: begin
            rdata_d = byte_q ? lane_ext : mem_rdata;
            state_d = DONE;
         end
         MERGE: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = lane_merged;
            state_d   = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         byte_q  <= 1'b0;
         lane_q  <= '0;
         waddr_q <= '0;
         wbyte_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         lane_q  <= lane_d;
         waddr_q <= waddr_d;
         wbyte_q <= wbyte_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign ready = (state_q == DONE);
   assign err   = ready && err_q;
   assign busy  = (state_q != IDLE);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 1-cycle SRAM.
module tb_mem_access_unit;

   localparam int ADDR_W = 6;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          en;
      int          wen;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req, we, byte_en;
   logic [31:0]       addr, wdata;
   logic              ready, err, busy;
   logic [31:0]       rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   logic [31:0]       sram [64];
   logic [31:0]       sram_rd = '0;
   logic [31:0]       ref_mem [64];
   logic              bd_we = 1'b0;
   logic [5:0]        bd_addr = '0;
   logic [31:0]       bd_data = '0;
   int                en_cnt = 0;
   int                we_cnt = 0;
   int                n_chk = 0;
   int                n_err = 0;
   exp_t              sb [$];

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .byte_en   (byte_en),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready),
      .rdata     (rdata),
      .err       (err),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge clk) begin
      if (bd_we) sram[bd_addr] <= bd_data;
      else if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        sram_rd <= sram[mem_addr];
      end
      if (mem_en) en_cnt++;
      if (mem_en && mem_we) we_cnt++;
   end
   assign mem_rdata = sram_rd;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic preload(input int wi, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 6'(wi); bd_data = d;
      ref_mem[wi] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, {27'b0, ready, err, busy, mem_en, mem_we}, 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_maddr"}, {26'b0, mem_addr}, 32'h0);
      check({tag, "_mwdata"}, mem_wdata, 32'h0);
   endtask

   // hold: leave req high after ready; b2b: issued during the previous DONE cycle
   task automatic do_op(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input bit b2b);
      exp_t e;
      exp_t got;
      int   wi, sh, cyc, en0, we0;
      @(negedge clk);
      req = 1'b1; we = w; byte_en = b; addr = a; wdata = d;
      wi = int'(a[7:2]);
      sh = 8 * int'(a[1:0]);
      e.err = !b && (a[1:0] != 2'b00);
      e.rdata = '0; e.en = 1; e.wen = 0;
      if (e.err) begin
         e.lat = 1; e.en = 0;
      end else if (w && !b) begin
         e.lat = 1; e.wen = 1; ref_mem[wi] = d;
      end else if (w) begin
         e.lat = 2; e.en = 2; e.wen = 1; ref_mem[wi][sh +: 8] = d[7:0];
      end else begin
         e.lat = 2;
         e.rdata = b ? ((ref_mem[wi] >> sh) & 32'hFF) : ref_mem[wi];
      end
      e.lat += int'(b2b);
      sb.push_back(e);
      en0 = en_cnt; we0 = we_cnt; cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (b2b && cyc == 1) check("busy_gap", {31'b0, busy}, 32'h0);
         if (cyc == 1 + int'(b2b)) check("busy_rise", {31'b0, busy}, 32'h1);
      end while (!ready && cyc < 8);
      check("ready", {31'b0, ready}, 32'h1);
      if (ready) begin
         got = sb.pop_front();
         check("latency", cyc, got.lat);
         check("rdata", rdata, got.rdata);
         check("err", {31'b0, err}, {31'b0, got.err});
         check("mem_en_cnt", en_cnt - en0, got.en);
         check("mem_we_cnt", we_cnt - we0, got.wen);
      end
      if (!hold) begin
         @(negedge clk);
         req = 1'b0;
      end
   endtask

   initial begin
      int we0;
      req = 1'b0; we = 1'b0; byte_en = 1'b0; addr = '0; wdata = '0;
      reset_n = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      preload(0, 32'h0);
      preload(24, 32'h0);
      preload(25, 32'h0);
      check_quiet("rst0");
      @(negedge clk); reset_n = 1'b1;

      do_op(1'b1, 1'b0, 32'h64, 32'h7, 0, 0);
      check("sram_w25", sram[25], ref_mem[25]);
      do_op(1'b0, 1'b0, 32'h64, 32'h0, 0, 0);

      preload(24, 32'hAABBCCDD);
      do_op(1'b0, 1'b1, 32'h61, 32'h0, 0, 0);
      do_op(1'b0, 1'b1, 32'h63, 32'h0, 0, 0);
      do_op(1'b0, 1'b1, 32'h60, 32'h0, 0, 0);

      do_op(1'b1, 1'b1, 32'h62, 32'h12345611, 0, 0);
      check("sram_w24_strb", sram[24], ref_mem[24]);

      do_op(1'b0, 1'b0, 32'h66, 32'h0, 0, 0);
      do_op(1'b1, 1'b0, 32'h65, 32'hFFFFFFFF, 0, 0);
      check("sram_w25_misal", sram[25], ref_mem[25]);
      do_op(1'b0, 1'b0, 32'h64, 32'h0, 0, 0);

      do_op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1, 0);
      do_op(1'b0, 1'b0, 32'hFFFFFF00, 32'h0, 1, 1);
      do_op(1'b1, 1'b1, 32'h103, 32'h55, 0, 1);
      check("sram_w0_wrap", sram[0], ref_mem[0]);
      @(posedge clk); #1;
      check("busy_idle", {31'b0, busy}, 32'h0);

      // Reset while the STRB read is in flight: the merge write must never happen.
      @(negedge clk);
      req = 1'b1; we = 1'b1; byte_en = 1'b1; addr = 32'h61; wdata = 32'h99;
      we0 = we_cnt;
      @(posedge clk); #1;
      check("busy_merge", {31'b0, busy}, 32'h1);
      reset_n = 1'b0;
      #1;
      check_quiet("rst_mid");
      repeat (2) @(negedge clk);
      check_quiet("rst_hold");
      req = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_we", we_cnt - we0, 32'h0);
      check("sram_w24_rst", sram[24], ref_mem[24]);
      do_op(1'b0, 1'b0, 32'h60, 32'h0, 0, 0);
      check("sb_empty", sb.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
